fetch_stage: RTL

Instruction-fetch stage of the pipelined core, directly upstream of decode. Owns the fetch PC, drives a synchronous-read instruction memory (1-cycle read latency), and presents the IF/ID payload (`instrD`, `pcD`, `pcplus4D`, `validD`) that decode consumes. A one-entry hold register and a two-state FSM keep `instrD` stable while the hazard unit stalls. The stage also squashes wrong-path fetches on an EX-stage redirect.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_pc_gen.sv | 37 +++
 rtl/fetch_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic {
        FS_STREAM,
        FS_HELD
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register and its next-PC priority mux: reset > redirect > stall > +4.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (redirect_i) begin
            pc_d = target_i & 32'hFFFF_FFFC;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, IF/ID register, stall hold FSM.
// Define FETCH_PERF_EN to add the fetchCount/killCount performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic                          stallF,
    input  logic                          flushD,
    input  logic                          pcsrcE,
    input  logic [31:0]                   pctargetE,
    output logic [31:0]                   imem_addr,
    input  logic [fetch_pkg::INSTR_W-1:0] imem_rdata,
    output logic [fetch_pkg::INSTR_W-1:0] instrD,
    output logic [31:0]                   pcD,
    output logic [31:0]                   pcplus4D,
    output logic                          validD
`ifdef FETCH_PERF_EN
   ,output logic [31:0]                   fetchCount,
    output logic [31:0]                   killCount
`endif
);

    import fetch_pkg::*;

    logic [31:0]        pc_f;
    logic [31:0]        pc_dec_q;
    logic               valid_dec_q;
    logic [INSTR_W-1:0] hold_instr_q;
    fetch_state_t       state_q;

    fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk_i      (CLK),
        .rst_i      (rst),
        .stall_i    (stallF),
        .redirect_i (pcsrcE),
        .target_i   (pctargetE),
        .pc_o       (pc_f)
    );

    // The memory relatches pc_f on every edge, including while stalled.
    assign imem_addr = pc_f;

    always_ff @(posedge CLK) begin
        if (rst) begin
            pc_dec_q    <= 32'd0;
            valid_dec_q <= 1'b0;
            state_q     <= FS_STREAM;
        end else if (pcsrcE) begin
            pc_dec_q    <= pc_f;
            valid_dec_q <= 1'b0;
            state_q     <= FS_STREAM;
        end else if (stallF) begin
            valid_dec_q <= valid_dec_q & ~flushD;
            if (state_q == FS_STREAM) begin
                state_q <= FS_HELD;
            end
        end else begin
            pc_dec_q    <= pc_f;
            valid_dec_q <= ~flushD;
            state_q     <= FS_STREAM;
        end
    end

    // NOTE: the hold register is pure data qualified by state_q/valid_dec_q, so it has no reset.
    always_ff @(posedge CLK) begin
        if (!rst && !pcsrcE && stallF && state_q == FS_STREAM) begin
            hold_instr_q <= imem_rdata;
        end
    end

    always_comb begin
        instrD = NOP_INSTR;
        if (valid_dec_q) begin
            instrD = (state_q == FS_HELD) ? hold_instr_q : imem_rdata;
        end
    end

    assign pcD      = pc_dec_q;
    assign pcplus4D = pc_dec_q + 32'd4;
    assign validD   = valid_dec_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] kill_cnt_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            if (!pcsrcE && !stallF && !flushD) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (pcsrcE || flushD) begin
                kill_cnt_q <= kill_cnt_q + 32'd1;
            end
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign killCount  = kill_cnt_q;
`endif

endmodule
